// File: rtl/fetch_sequencer.sv
// fetch_sequencer: 6502 opcode/operand fetch in front of the decoder; FETCH_RESET_VECTOR_EN adds the FFFC/FFFD reset-vector fetch
module fetch_sequencer #(
  parameter int ADDR_WIDTH = 16,
  parameter int REG_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(16'h0600)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  input  logic [REG_WIDTH-1:0]  mem_data,
  input  logic                  mem_ready,
  output logic [REG_WIDTH-1:0]  instruction_out,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic                  instruction_ready,
  input  logic                  instruction_done,
  input  logic                  pc_load,
  input  logic [ADDR_WIDTH-1:0] pc_load_value,
  input  logic                  halt,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  busy
);
`ifdef FETCH_RESET_VECTOR_EN
  typedef enum logic [2:0] {FETCH_OP, FETCH_LO, FETCH_HI, ISSUE, WAIT_DONE, HALTED, VEC_LO, VEC_HI} state_t;
  localparam state_t START = VEC_LO;
`else
  typedef enum logic [2:0] {FETCH_OP, FETCH_LO, FETCH_HI, ISSUE, WAIT_DONE, HALTED} state_t;
  localparam state_t START = FETCH_OP;
`endif
  state_t state, state_next;
  logic [REG_WIDTH-1:0] lo, hi;
  logic [1:0] len, op_len;
  logic [2:0] bbb;
  logic [1:0] cc;
  logic xfer, fetching, rd_next;
  logic [ADDR_WIDTH-1:0] pc_next, addr_next;
  assign xfer = mem_rd & mem_ready;
  assign fetching = state == FETCH_OP || state == FETCH_LO || state == FETCH_HI;
  assign busy = state != HALTED;
  assign bbb = mem_data[4:2];
  assign cc = mem_data[1:0];
  assign op_len = (bbb == 3'b011 || bbb == 3'b110 || bbb == 3'b111) ? 2'd2 :
                  (cc == 2'b10 && bbb == 3'b010) ? 2'd0 : 2'd1;
  // state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= START;
    else state <= state_next;
  // next-state: read states advance only on a completed read
  always_comb begin
    state_next = state;
    case (state)
      FETCH_OP:  state_next = xfer ? (op_len == 2'd0 ? ISSUE : FETCH_LO) : FETCH_OP;
      FETCH_LO:  state_next = xfer ? (len == 2'd2 ? FETCH_HI : ISSUE) : FETCH_LO;
      FETCH_HI:  state_next = xfer ? ISSUE : FETCH_HI;
      ISSUE:     state_next = WAIT_DONE;
      WAIT_DONE: state_next = instruction_done ? (halt ? HALTED : FETCH_OP) : WAIT_DONE;
      HALTED:    state_next = halt ? HALTED : FETCH_OP;
`ifdef FETCH_RESET_VECTOR_EN
      VEC_LO:    state_next = xfer ? VEC_HI : VEC_LO;
      VEC_HI:    state_next = xfer ? FETCH_OP : VEC_HI;
`endif
      default:   state_next = START;
    endcase
  end
  // next PC: post-increment per fetched byte, decoder redirect, or vector load
  always_comb begin
    pc_next = (xfer && fetching) ? pc + ADDR_WIDTH'(1) : pc;
    if (state == WAIT_DONE && instruction_done && pc_load) pc_next = pc_load_value;
`ifdef FETCH_RESET_VECTOR_EN
    if (state == VEC_HI && xfer) pc_next = ADDR_WIDTH'({mem_data, lo});
`endif
  end
  // read request for the cycle after this edge, so back-to-back reads need no idle cycle
  always_comb begin
    rd_next = state_next == FETCH_OP || state_next == FETCH_LO || state_next == FETCH_HI;
    addr_next = pc_next;
`ifdef FETCH_RESET_VECTOR_EN
    rd_next = rd_next || state_next == VEC_LO || state_next == VEC_HI;
    addr_next = state_next == VEC_LO ? ADDR_WIDTH'(16'hFFFC) :
                state_next == VEC_HI ? ADDR_WIDTH'(16'hFFFD) : pc_next;
`endif
  end
  // datapath: memory port, PC, captured bytes and decoder handoff
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      mem_rd <= 1'b0;
      mem_addr <= '0;
      pc <= RESET_PC;
      instruction_out <= '0;
      addr_out <= '0;
      instruction_ready <= 1'b0;
      len <= 2'd0;
      lo <= '0;
      hi <= '0;
    end else begin
      mem_rd <= rd_next;
      mem_addr <= rd_next ? addr_next : '0;
      pc <= pc_next;
      if (state == FETCH_OP && xfer) begin
        instruction_out <= mem_data;
        len <= op_len;
      end
      if (state == FETCH_LO && xfer) lo <= mem_data;
      if (state == FETCH_HI && xfer) hi <= mem_data;
`ifdef FETCH_RESET_VECTOR_EN
      if (state == VEC_LO && xfer) lo <= mem_data;
`endif
      if (state == ISSUE) begin
        addr_out <= len == 2'd0 ? '0 : len == 2'd1 ? ADDR_WIDTH'(lo) : ADDR_WIDTH'({hi, lo});
        instruction_ready <= 1'b1;
      end
      if (state == WAIT_DONE && instruction_done) instruction_ready <= 1'b0;
    end
endmodule
